// File: rtl/spi_master_param.sv
// Parametrised SPI master: one DATA_W-bit word per start, MSB first, runtime CPOL/CPHA,
// programmable SCLK half-period and one-hot active-low chip selects.
module spi_master_param #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned DIV_W  = 8,
  localparam int unsigned CsW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int unsigned CntW  = $clog2(2 * DATA_W) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [DIV_W-1:0]  clk_div_i,
  input  logic [CsW-1:0]    cs_sel_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [NUM_CS-1:0] cs_n_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StDone} state_e;

  localparam logic [CntW-1:0] LastEdge = CntW'(2 * DATA_W - 1);

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d, div_q, div_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic                tick, leading;

  // Out-of-range selects decode to all-ones, so no slave is addressed.
  function automatic logic [NUM_CS-1:0] cs_decode(logic [CsW-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CsW'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  assign tick    = (cnt_q == div_q);
  assign leading = ~bit_cnt_q[0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    cs_n_d    = cs_n_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        sclk_d = cpol_i;
        mosi_d = 1'b0;
        cs_n_d = '1;
        busy_d = 1'b0;
        if (start_i) begin
          state_d   = StSetup;
          cnt_d     = '0;
          bit_cnt_d = '0;
          div_d     = clk_div_i;
          cpol_d    = cpol_i;
          cpha_d    = cpha_i;
          cs_n_d    = cs_decode(cs_sel_i);
          busy_d    = 1'b1;
          rx_sh_d   = '0;
          if (cpha_i) begin
            tx_sh_d = tx_data_i;
          end else begin
            mosi_d  = tx_data_i[DATA_W-1];
            tx_sh_d = tx_data_i << 1;
          end
        end
      end
      StSetup, StXfer: begin
        if (tick) begin
          cnt_d     = '0;
          sclk_d    = ~sclk_q;
          bit_cnt_d = bit_cnt_q + CntW'(1);
          state_d   = (bit_cnt_q == LastEdge) ? StHold : StXfer;
          // cpha=0 samples on leading edges, cpha=1 on trailing edges.
          if (leading != cpha_q) rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_i};
          if (cpha_q ? leading : (!leading && bit_cnt_q != LastEdge)) begin
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = tx_sh_q << 1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StHold: begin
        sclk_d = cpol_q;
        if (tick) begin
          state_d = StDone;
          cs_n_d  = '1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      cs_n_q    <= '1;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      cs_n_q    <= cs_n_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;
  assign rx_data_o = rx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: vector table with a done-driven scoreboard, an independent
// SPI slave model, plus back-to-back, abort and out-of-range-select sequences.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [7:0]  clk_div = 8'd0;
  logic [1:0]  cs_sel = 2'd0;
  logic [15:0] tx_data = 16'd0;
  logic        miso, loop = 1'b1, slv_miso = 1'b0;
  logic        sclk, mosi, busy, done;
  logic [3:0]  cs_n;
  logic [15:0] rx_data;
  logic        sclk3, mosi3, busy3, done3;
  logic [2:0]  cs_n3;
  logic [15:0] rx3;

  always #5 clk = ~clk;

  assign miso = loop ? mosi : slv_miso;

  spi_master_param #(.DATA_W(16), .NUM_CS(4), .DIV_W(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cpol_i(cpol), .cpha_i(cpha),
    .clk_div_i(clk_div), .cs_sel_i(cs_sel), .tx_data_i(tx_data), .miso_i(miso),
    .sclk_o(sclk), .mosi_o(mosi), .cs_n_o(cs_n), .rx_data_o(rx_data),
    .busy_o(busy), .done_o(done)
  );

  spi_master_param #(.DATA_W(16), .NUM_CS(3), .DIV_W(8)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cpol_i(cpol), .cpha_i(cpha),
    .clk_div_i(clk_div), .cs_sel_i(cs_sel), .tx_data_i(tx_data), .miso_i(miso),
    .sclk_o(sclk3), .mosi_o(mosi3), .cs_n_o(cs_n3), .rx_data_o(rx3),
    .busy_o(busy3), .done_o(done3)
  );

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [7:0]  div;
    logic [1:0]  cs;
    logic [15:0] tx;
    logic [15:0] reply;
    logic        loop;
    logic [3:0]  exp_cs;
    int          dc;
    logic [15:0] exp_rx;
  } vec_t;

  typedef struct {
    logic [15:0] rx;
    int          cyc;
    int          tog0;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[7];
  int   n_vec = 0, n_err = 0, cyc = 0, tog = 0, tog3 = 0, done_cnt = 0, done3_cnt = 0;
  bit   cs3_low = 1'b0, div3 = 1'b0;
  logic sclk_p, sclk3_p;

  // Slave model state
  bit          slv_on = 1'b0, slv_cpha = 1'b0;
  int          slv_edge = 0, slv_idx = 0;
  logic [15:0] slv_tx = 16'd0, slv_rx = 16'd0;
  logic        slv_sclk_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor and scoreboard: expected words are popped as done pulses appear.
  initial forever begin
    sb_t e;
    @(negedge clk);
    if (busy && sclk !== sclk_p) tog++;
    sclk_p = sclk;
    if (busy3 && sclk3 !== sclk3_p) tog3++;
    sclk3_p = sclk3;
    if (rst_n && cs_n3 !== 3'b111) cs3_low = 1'b1;
    if (rst_n && mosi3 !== mosi) div3 = 1'b1;
    if (rst_n && done3) done3_cnt++;
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.rx));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("sclk_edges", 32'(tog - e.tog0), 32'd32);
      end
    end
  end

  // SPI slave: shifts slv_tx out on miso and captures mosi, following the chosen mode.
  initial forever begin
    bit lead;
    @(negedge clk);
    if (!slv_on && rst_n && cs_n !== 4'hF) begin
      slv_on   = 1'b1;
      slv_edge = 0;
      slv_rx   = 16'd0;
      slv_miso = slv_cpha ? 1'b0 : slv_tx[15];
      slv_idx  = slv_cpha ? 15 : 14;
    end else if (slv_on) begin
      if (cs_n === 4'hF) begin
        slv_on = 1'b0;
      end else if (sclk !== slv_sclk_p) begin
        lead = (slv_edge % 2) == 0;
        if (lead != slv_cpha) slv_rx = {slv_rx[14:0], mosi};
        if (slv_cpha ? lead : (!lead && slv_edge != 31)) begin
          slv_miso = slv_tx[slv_idx];
          slv_idx--;
        end
        slv_edge++;
      end
    end
    slv_sclk_p = sclk;
  end

  task automatic run_vec(input vec_t v);
    bit seen;
    loop     = v.loop;
    slv_cpha = v.cpha;
    slv_tx   = v.reply;
    cpol     = v.cpol;
    repeat (2) @(negedge clk);
    chk("idle_sclk", 32'(sclk), 32'(v.cpol));
    cpha = v.cpha; clk_div = v.div; cs_sel = v.cs; tx_data = v.tx; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    sb.push_back('{rx: v.exp_rx, cyc: cyc + v.dc - 1, tog0: tog});
    chk("xfer_cs_n", 32'(cs_n), 32'(v.exp_cs));
    chk("xfer_busy", 32'(busy), 32'd1);
    // Scramble inputs and pulse start mid-transfer; none of it may take effect.
    repeat (4) @(negedge clk);
    tx_data = ~tx_data; cpol = ~v.cpol; cpha = ~v.cpha; clk_div = 8'd5;
    cs_sel = cs_sel + 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("hold_sclk", 32'(sclk), 32'(v.cpol));
      chk("done_cs_n", 32'(cs_n), 32'hF);
      if (!v.loop) chk("slave_rx", 32'(slv_rx), 32'(v.tx));
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_cs_n", 32'(cs_n), 32'hF);
    end
  endtask

  initial begin
    vec_t oor;
    bit   seen;
    int   d0, t3, d3;
    vecs[0] = '{1'b0, 1'b0, 8'd0, 2'd0, 16'hA5A5, 16'h5A5A, 1'b0, 4'hE, 34, 16'h5A5A};
    vecs[1] = '{1'b0, 1'b0, 8'd3, 2'd1, 16'h1234, 16'h0000, 1'b1, 4'hD, 133, 16'h1234};
    vecs[2] = '{1'b0, 1'b1, 8'd3, 2'd1, 16'h1234, 16'h0000, 1'b1, 4'hD, 133, 16'h1234};
    vecs[3] = '{1'b1, 1'b0, 8'd3, 2'd1, 16'h1234, 16'h0000, 1'b1, 4'hD, 133, 16'h1234};
    vecs[4] = '{1'b1, 1'b1, 8'd3, 2'd1, 16'h1234, 16'h0000, 1'b1, 4'hD, 133, 16'h1234};
    vecs[5] = '{1'b1, 1'b1, 8'd1, 2'd3, 16'hBEEF, 16'h0F0F, 1'b0, 4'h7, 67, 16'h0F0F};
    vecs[6] = '{1'b0, 1'b1, 8'd0, 2'd2, 16'h8001, 16'h6C93, 1'b0, 4'hB, 34, 16'h6C93};
    oor     = '{1'b0, 1'b1, 8'd0, 2'd3, 16'h0F0F, 16'h0000, 1'b1, 4'h7, 34, 16'h0F0F};

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back with start held high, cs_sel 2 then 3
    loop = 1'b1; cpol = 1'b0;
    repeat (2) @(negedge clk);
    cpha = 1'b0; clk_div = 8'd0; cs_sel = 2'd2; tx_data = 16'hC3A1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{rx: 16'hC3A1, cyc: cyc + 33, tog0: tog});
    d0 = cyc;
    chk("b2b_cs1", 32'(cs_n), 32'hB);
    tx_data = 16'h7E18; cs_sel = 2'd3;
    repeat (32) @(negedge clk);
    chk("b2b_busy33", 32'(busy), 32'd1);
    chk("b2b_cs33", 32'(cs_n), 32'hB);
    @(negedge clk);
    chk("b2b_done34", 32'(done), 32'd1);
    chk("b2b_cs34", 32'(cs_n), 32'hF);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_cs", 32'(cs_n), 32'hF);
    sb.push_back('{rx: 16'h7E18, cyc: d0 + 68, tog0: tog});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_cs2", 32'(cs_n), 32'h7);
    chk("b2b_busy2", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("b2b_done2_seen", 32'(seen), 32'd1);

    // Abort by reset at cycle 10 of a transfer
    loop = 1'b1; cpol = 1'b1;
    repeat (2) @(negedge clk);
    cpha = 1'b0; clk_div = 8'd3; cs_sel = 2'd1; tx_data = 16'hF00F; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    repeat (9) @(negedge clk);
    chk("abort_pre_cs", 32'(cs_n), 32'hD);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'hF);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_mosi", 32'(mosi), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rx", 32'(rx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_vec(vecs[1]);

    // Out-of-range select on the NUM_CS=3 instance
    t3 = tog3; d3 = done3_cnt; cs3_low = 1'b0; div3 = 1'b0;
    run_vec(oor);
    chk("oor_cs_never_low", 32'(cs3_low), 32'd0);
    chk("oor_sclk_edges", 32'(tog3 - t3), 32'd32);
    chk("oor_done", 32'(done3_cnt - d3), 32'd1);
    chk("oor_rx", 32'(rx3), 32'h0F0F);
    chk("oor_mosi_match", 32'(div3), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
